// File: rtl/pipelined_register_file.sv
// LEGv8 integer register file: two combinational read ports, one write port, hardwired zero
// register and a sequential clear engine. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module pipelined_register_file #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy,
  output logic              ready
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [0:0]        st;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic              do_write;

  // An index is usable only if it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && (32'(a) != ZERO_REG);
  endfunction

  assign busy     = reset | (st == CLEAR);
  assign ready    = ~busy;
  assign do_write = (st == RUN) && !reset && !clear_req && wr_en && addr_ok(wr_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      st      <= CLEAR;
      clr_idx <= '0;
    end else if (st == CLEAR) begin
      if (32'(clr_idx) == NUM_REGS - 1) begin
        st      <= RUN;
        clr_idx <= '0;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end else if (clear_req) begin
      st      <= CLEAR;
      clr_idx <= '0;
    end
  end

  // Storage has no reset of its own; the clear engine is what defines every entry.
  always_ff @(posedge clock) begin
    if (!reset && st == CLEAR) begin
      rf[clr_idx[IDX_W-1:0]] <= '0;
    end else if (do_write) begin
      rf[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!busy && addr_ok(a)) begin
`ifdef RF_BYPASS_EN
      if (do_write && wr_addr == a) v = wr_data;
      else v = rf[a[IDX_W-1:0]];
`else
      v = rf[a[IDX_W-1:0]];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
  end

endmodule

// File: tb/tb_pipelined_register_file.sv
// Scoreboard bench for pipelined_register_file: a 32-entry instance and a 16-entry instance
// (zero register 15) share stimulus; expectations are queued and checked by a negedge monitor.
module tb_pipelined_register_file;

  localparam int K_RD1 = 0, K_RD2 = 1, K_BUSY = 2, K_READY = 3, K_SRD1 = 4, K_SRD2 = 5, K_SBUSY = 6;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, clear_req, wr_en;
  logic [4:0]  wr_addr, rd_addr1, rd_addr2;
  logic [63:0] wr_data;
  logic [63:0] rd_data1, rd_data2, s_rd_data1, s_rd_data2;
  logic        busy, ready, s_busy, s_ready;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  pipelined_register_file dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .busy(busy), .ready(ready)
  );

  pipelined_register_file #(.DATA_W(64), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(15)) dut16 (
    .clock(clock), .reset(reset), .clear_req(clear_req), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(s_rd_data1), .rd_data2(s_rd_data2), .busy(s_busy), .ready(s_ready)
  );

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] pick(input int kind);
    case (kind)
      K_RD1:   return rd_data1;
      K_RD2:   return rd_data2;
      K_BUSY:  return 64'(busy);
      K_READY: return 64'(ready);
      K_SRD1:  return s_rd_data1;
      K_SRD2:  return s_rd_data2;
      default: return 64'(s_busy);
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle and compares it against the live outputs.
  always @(negedge clock) begin
    exp_t e;
    logic [63:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = pick(e.kind);
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic clr, input logic we,
                               input logic [4:0] wa, input logic [63:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2);
    reset = rst; clear_req = clr; wr_en = we;
    wr_addr = wa; wr_data = wd; rd_addr1 = ra1; rd_addr2 = ra2;
  endtask

  task automatic checkOutput(input int kind, input logic [63:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [63:0] v5, va, vff;
    v5  = 64'hDEAD_BEEF_0123_4567;
    va  = 64'hAAAA_5555_AAAA_5555;
    vff = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset held for 3 cycles: busy, not ready, reads forced to zero.
    applyStimulus(1, 0, 0, 5'd0, 64'd0, 5'd5, 5'd5);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput(K_BUSY, 64'd1, "reset_busy");
      checkOutput(K_READY, 64'd0, "reset_ready");
      checkOutput(K_RD1, 64'd0, "reset_rd1");
      checkOutput(K_RD2, 64'd0, "reset_rd2");
      step();
    end

    // Clear after reset: 32 busy cycles (16 for the small instance).
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd0, 5'd0);
    for (int k = 0; k <= 32; k++) begin
      checkOutput(K_BUSY, 64'(k < 32), $sformatf("post_reset_busy_k%0d", k));
      checkOutput(K_READY, 64'(k >= 32), $sformatf("post_reset_ready_k%0d", k));
      checkOutput(K_SBUSY, 64'(k < 16), $sformatf("s_post_reset_busy_k%0d", k));
      step();
    end

    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      checkOutput(K_RD1, 64'd0, $sformatf("cleared_rd1_%0d", i));
      checkOutput(K_RD2, 64'd0, $sformatf("cleared_rd2_%0d", 31 - i));
      step();
    end

    // Write then read on both ports.
    applyStimulus(0, 0, 1, 5'd5, v5, 5'd5, 5'd5);
    checkOutput(K_RD1, BYP ? v5 : 64'd0, "wr5_same_cycle_rd1");
    step();
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd5, 5'd5);
    checkOutput(K_RD1, v5, "wr5_rd1");
    checkOutput(K_RD2, v5, "wr5_rd2");
    step();

    // Zero register ignores writes and never forwards.
    applyStimulus(0, 0, 1, 5'd30, va, 5'd30, 5'd30);
    step();
    applyStimulus(0, 0, 1, 5'd31, vff, 5'd31, 5'd30);
    checkOutput(K_RD1, 64'd0, "zero_reg_same_cycle");
    checkOutput(K_RD2, va, "r30_same_cycle");
    step();
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd31, 5'd30);
    checkOutput(K_RD1, 64'd0, "zero_reg_after");
    checkOutput(K_RD2, va, "r30_after");
    step();

    // Clear request wins over a same-cycle write.
    applyStimulus(0, 0, 1, 5'd7, 64'h11, 5'd7, 5'd8);
    step();
    applyStimulus(0, 1, 1, 5'd8, 64'h22, 5'd7, 5'd8);
    checkOutput(K_RD1, 64'h11, "r7_before_clear");
    checkOutput(K_RD2, 64'd0, "r8_no_fwd_on_clear");
    checkOutput(K_BUSY, 64'd0, "clear_req_cycle_busy");
    step();
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd7, 5'd8);
    for (int k = 0; k <= 32; k++) begin
      checkOutput(K_BUSY, 64'(k < 32), $sformatf("clear_busy_k%0d", k));
      checkOutput(K_SBUSY, 64'(k < 16), $sformatf("s_clear_busy_k%0d", k));
      if (k == 0) checkOutput(K_RD1, 64'd0, "read_during_clear");
      step();
    end
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd7, 5'd8);
    checkOutput(K_RD1, 64'd0, "r7_after_clear");
    checkOutput(K_RD2, 64'd0, "r8_write_dropped");
    step();
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd5, 5'd30);
    checkOutput(K_RD1, 64'd0, "r5_after_clear");
    checkOutput(K_RD2, 64'd0, "r30_after_clear");
    step();

    // Reset at clear edge 10 restarts the sequence; a write during busy is lost.
    applyStimulus(0, 0, 1, 5'd2, 64'h0202, 5'd2, 5'd2);
    step();
    applyStimulus(0, 1, 0, 5'd0, 64'd0, 5'd2, 5'd2);
    checkOutput(K_RD1, 64'h0202, "r2_before_clear");
    step();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd2, 5'd2);
      checkOutput(K_BUSY, 64'd1, $sformatf("midclear_busy_k%0d", k));
      step();
    end
    applyStimulus(1, 0, 0, 5'd0, 64'd0, 5'd2, 5'd2);
    checkOutput(K_BUSY, 64'd1, "midclear_reset_busy");
    step();
    for (int k = 0; k <= 32; k++) begin
      if (k == 20) applyStimulus(0, 0, 1, 5'd2, 64'h9999, 5'd2, 5'd2);
      else applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd2, 5'd2);
      checkOutput(K_BUSY, 64'(k < 32), $sformatf("restart_busy_k%0d", k));
      checkOutput(K_SBUSY, 64'(k < 16), $sformatf("s_restart_busy_k%0d", k));
      step();
    end
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd2, 5'd2);
    checkOutput(K_RD1, 64'd0, "busy_write_lost");
    step();

    // 16-entry instance: out-of-range write dropped, index 15 is the zero register.
    applyStimulus(0, 0, 1, 5'd20, 64'h2020, 5'd20, 5'd15);
    step();
    applyStimulus(0, 0, 1, 5'd15, 64'h1515, 5'd20, 5'd15);
    checkOutput(K_SRD1, 64'd0, "s_oor_write_dropped");
    checkOutput(K_RD1, 64'h2020, "r20_written");
    step();
    applyStimulus(0, 0, 1, 5'd14, 64'h1414, 5'd15, 5'd14);
    checkOutput(K_SRD1, 64'd0, "s_zero_reg15");
    checkOutput(K_RD1, 64'h1515, "r15_written");
    checkOutput(K_SRD2, BYP ? 64'h1414 : 64'd0, "s_r14_same_cycle");
    step();
    applyStimulus(0, 0, 0, 5'd0, 64'd0, 5'd15, 5'd14);
    checkOutput(K_SRD1, 64'd0, "s_zero_reg15_after");
    checkOutput(K_SRD2, 64'h1414, "s_r14_after");
    checkOutput(K_RD2, 64'h1414, "r14_after");
    step();

    step();
    step();
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
